apple1_pia: RTL and testbench

- Apple-I keyboard/display I/O register block, emulating the 6821 PIA at $D010-$D013.
- Sits beside the WozMon ROM on the CPU bus. It decodes AB/WE/DO from the CPU core and returns registered read data plus a select flag to the top-level DI mux.
- Host-side keyboard input uses a valid/ready stream into a small FIFO. Display output uses a valid/ready stream out.

---
 rtl/apple1_pkg.sv | 29 ++
 rtl/apple1_kbd_fifo.sv | 70 +++++++
 rtl/apple1_pia.sv | 153 +++++++++++++++
 tb/tb_apple1_pia.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared constants for the Apple-I PIA register block.
//   PIA_BASE          default base address of the 4-byte register window
//   *_OFS             register offsets inside the window (AB[1:0])
//   CR_ORSEL_BIT      control-register bit that selects the data register
//                     instead of DDR at offsets 0 and 2
//   ascii_upcase()    maps 'a'..'z' to 'A'..'Z' and leaves every other code unchanged
package apple1_pkg;

    localparam logic [15:0] PIA_BASE = 16'hD010;

    localparam logic [1:0] KBD_OFS   = 2'd0;
    localparam logic [1:0] KBDCR_OFS = 2'd1;
    localparam logic [1:0] DSP_OFS   = 2'd2;
    localparam logic [1:0] DSPCR_OFS = 2'd3;

    localparam int CR_ORSEL_BIT = 2;

    localparam logic [6:0] ASCII_LC_A       = 7'h61;
    localparam logic [6:0] ASCII_LC_Z       = 7'h7A;
    localparam logic [6:0] ASCII_CASE_DELTA = 7'h20;

    function automatic logic [6:0] ascii_upcase(input logic [6:0] c);
        if (c >= ASCII_LC_A && c <= ASCII_LC_Z) begin
            return c - ASCII_CASE_DELTA;
        end
        return c;
    endfunction

endpackage

// File: rtl/apple1_kbd_fifo.sv
// Small synchronous first-word-fall-through FIFO for keyboard characters.
//   clk, reset   clock and synchronous active-high reset (flushes the pointers)
//   push         write push_data when not full (ignored while full)
//   pop          drop the head entry when not empty (ignored while empty)
//   head         current head entry (only meaningful while !empty)
//   full, empty  occupancy flags
module apple1_kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/apple1_pia.sv
// Apple-I keyboard/display register block emulating the 6821 PIA window.
//   clk, reset           CPU clock, synchronous active-high reset
//   AB, cpu_do, WE, RDY  CPU bus: address, write data, write enable, ready
//   dout, sel            registered read data and "previous cycle was a read hit"
//   kbd_data/valid/ready host keyboard stream into the FIFO
//   dsp_data/valid/ready display character stream out
module apple1_pia
    import apple1_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = PIA_BASE,
    parameter int          KBD_DEPTH = 4,
    parameter bit          UPCASE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  cpu_do,
    input  logic        WE,
    input  logic        RDY,
    output logic [7:0]  dout,
    output logic        sel,
    input  logic [6:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [6:0]  dsp_data,
    output logic        dsp_valid,
    input  logic        dsp_ready
);

    logic [7:0] dout_reg;
    logic       sel_reg;
    logic [6:0] kbdcr_reg;
    logic [6:0] dspcr_reg;
    logic [7:0] ddra_reg;
    logic [6:0] ddrb_reg;
    logic [6:0] last_char_reg;
    logic [6:0] dsp_data_reg;
    logic       dsp_valid_reg;

    logic [1:0] ofs;
    logic       hit;
    logic       bus_rd;
    logic       bus_wr;
    logic       kbd_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [6:0] fifo_head;
    logic [6:0] fifo_push_data;
    logic [7:0] rd_value;
    logic       dsp_char_wr;
    logic       dsp_xfer;

    assign ofs    = AB[1:0];
    assign hit    = (AB[15:2] == BASE_ADDR[15:2]) && RDY;
    assign bus_rd = hit && !WE;
    assign bus_wr = hit && WE;

    // A KBD read in data mode pops; the FIFO itself ignores the pop when empty.
    assign kbd_pop        = bus_rd && (ofs == KBD_OFS) && kbdcr_reg[CR_ORSEL_BIT];
    assign fifo_push_data = UPCASE ? ascii_upcase(kbd_data) : kbd_data;
    assign kbd_ready      = !fifo_full;

    assign dsp_char_wr = bus_wr && (ofs == DSP_OFS) && dspcr_reg[CR_ORSEL_BIT];
    assign dsp_xfer    = dsp_valid_reg && dsp_ready;

    apple1_kbd_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (7)
    ) u_kbd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kbd_valid),
        .push_data (fifo_push_data),
        .pop       (kbd_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        rd_value = 8'h00;
        case (ofs)
            KBD_OFS: begin
                if (kbdcr_reg[CR_ORSEL_BIT]) begin
                    // An empty FIFO repeats the last character instead of underflowing.
                    rd_value = {1'b1, fifo_empty ? last_char_reg : fifo_head};
                end else begin
                    rd_value = ddra_reg;
                end
            end
            KBDCR_OFS: rd_value = {!fifo_empty, kbdcr_reg};
            DSP_OFS:   rd_value = {dsp_valid_reg,
                                   dspcr_reg[CR_ORSEL_BIT] ? dsp_data_reg : ddrb_reg};
            default:   rd_value = {1'b0, dspcr_reg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg      <= 8'h00;
            sel_reg       <= 1'b0;
            kbdcr_reg     <= 7'h00;
            dspcr_reg     <= 7'h00;
            ddra_reg      <= 8'h00;
            ddrb_reg      <= 7'h00;
            last_char_reg <= 7'h00;
        end else begin
            sel_reg <= bus_rd;
            if (bus_rd) begin
                dout_reg <= rd_value;
            end
            if (kbd_pop && !fifo_empty) begin
                last_char_reg <= fifo_head;
            end
            if (bus_wr) begin
                case (ofs)
                    KBD_OFS: begin
                        if (!kbdcr_reg[CR_ORSEL_BIT]) begin
                            ddra_reg <= cpu_do;
                        end
                    end
                    KBDCR_OFS: kbdcr_reg <= cpu_do[6:0];
                    DSP_OFS: begin
                        if (!dspcr_reg[CR_ORSEL_BIT]) begin
                            ddrb_reg <= cpu_do[6:0];
                        end
                    end
                    default: dspcr_reg <= cpu_do[6:0];
                endcase
            end
        end
    end

    // Busy is judged from the registered valid, so a character write landing
    // on the same edge as a handshake is dropped rather than queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_valid_reg <= 1'b0;
            dsp_data_reg  <= 7'h00;
        end else if (dsp_xfer) begin
            dsp_valid_reg <= 1'b0;
        end else if (dsp_char_wr && !dsp_valid_reg) begin
            dsp_data_reg  <= cpu_do[6:0];
            dsp_valid_reg <= 1'b1;
        end
    end

    assign dout      = dout_reg;
    assign sel       = sel_reg;
    assign dsp_data  = dsp_data_reg;
    assign dsp_valid = dsp_valid_reg;

endmodule

// File: tb/tb_apple1_pia.sv
// Directed testbench for apple1_pia (default parameters).
module tb_apple1_pia;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  cpu_do;
    logic        WE;
    logic        RDY;
    logic [7:0]  dout;
    logic        sel;
    logic [6:0]  kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [6:0]  dsp_data;
    logic        dsp_valid;
    logic        dsp_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    logic [6:0] xfer_data = 7'h00;

    always #5 clk = ~clk;

    apple1_pia dut (
        .clk       (clk),
        .reset     (reset),
        .AB        (AB),
        .cpu_do    (cpu_do),
        .WE        (WE),
        .RDY       (RDY),
        .dout      (dout),
        .sel       (sel),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .dsp_data  (dsp_data),
        .dsp_valid (dsp_valid),
        .dsp_ready (dsp_ready)
    );

    // Display-side consumer: records every completed handshake.
    always @(posedge clk) begin
        if (!reset && dsp_valid && dsp_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            xfer_data <= dsp_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-28s observed %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle presented for one clock edge; returns on the following
    // negedge, where dout/sel reflect that cycle.
    task automatic bus(input logic [15:0] a, input logic we, input logic [7:0] d,
                       input logic rdy);
        @(negedge clk);
        AB = a; WE = we; cpu_do = d; RDY = rdy;
        @(negedge clk);
        AB = 16'h0000; WE = 1'b0; RDY = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a);
        bus(a, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b1, d, 1'b1);
    endtask

    task automatic kpush(input logic [6:0] c);
        @(negedge clk);
        kbd_data = c; kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; AB = 16'h0000; cpu_do = 8'h00; WE = 1'b0; RDY = 1'b1;
        kbd_data = 7'h00; kbd_valid = 1'b0; dsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset dout", dout, 8'h00);
        check("reset sel", {7'h0, sel}, 8'h01 & 8'h00);
        check("reset kbd_ready", {7'h0, kbd_ready}, 8'h01);
        check("reset dsp_valid", {7'h0, dsp_valid}, 8'h00);
        rd(16'hD011);
        check("rd KBDCR sel", {7'h0, sel}, 8'h01);
        check("rd KBDCR after reset", dout, 8'h00);
        @(negedge clk);
        check("sel drops when idle", {7'h0, sel}, 8'h00);

        // WozMon init
        wr(16'hD012, 8'h7F);
        wr(16'hD011, 8'hA7);
        wr(16'hD013, 8'hA7);
        check("init dsp_valid", {7'h0, dsp_valid}, 8'h00);
        rd(16'hD013);
        check("rd DSPCR", dout, 8'h27);

        // Single keystroke with upcase
        kpush(7'h61);
        rd(16'hD011);
        check("KBDCR with char", dout, 8'hA7);
        rd(16'hD010);
        check("KBD 'a' upcased", dout, 8'hC1);
        rd(16'hD011);
        check("KBDCR after pop", dout, 8'h27);

        // Fill past depth; upcase boundaries 'z', '`', '{'
        kpush(7'h7A);
        kpush(7'h60);
        kpush(7'h7B);
        check("kbd_ready before 4th", {7'h0, kbd_ready}, 8'h01);
        kpush(7'h42);
        check("kbd_ready full", {7'h0, kbd_ready}, 8'h00);
        kpush(7'h33);
        rd(16'hD010);
        check("pop1 'z'->'Z'", dout, 8'hDA);
        check("kbd_ready after pop", {7'h0, kbd_ready}, 8'h01);
        rd(16'hD010);
        check("pop2 '`' kept", dout, 8'hE0);
        rd(16'hD010);
        check("pop3 '{' kept", dout, 8'hFB);
        rd(16'hD010);
        check("pop4 'B'", dout, 8'hC2);
        rd(16'hD010);
        check("empty read repeats last", dout, 8'hC2);
        rd(16'hD011);
        check("5th push was dropped", dout, 8'h27);

        // Display output
        wr(16'hD012, 8'h8D);
        check("dsp_valid after write", {7'h0, dsp_valid}, 8'h01);
        check("dsp_data after write", {1'b0, dsp_data}, 8'h0D);
        rd(16'hD012);
        check("DSP busy bit set", {7'h0, dout[7]}, 8'h01);
        wr(16'hD012, 8'hC1);
        check("busy write dropped", {1'b0, dsp_data}, 8'h0D);
        @(negedge clk);
        dsp_ready = 1'b1;
        @(negedge clk);
        check("dsp_valid clears", {7'h0, dsp_valid}, 8'h00);
        dsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("one transfer", 8'(xfer_cnt), 8'd1);
        check("transfer data", {1'b0, xfer_data}, 8'h0D);
        rd(16'hD012);
        check("DSP busy bit clear", {7'h0, dout[7]}, 8'h00);

        // CPU write on the same edge as a handshake is dropped
        wr(16'hD012, 8'h8D);
        @(negedge clk);
        dsp_ready = 1'b1; AB = 16'hD012; WE = 1'b1; cpu_do = 8'hC2;
        @(negedge clk);
        dsp_ready = 1'b0; AB = 16'h0000; WE = 1'b0;
        check("write at xfer dropped", {7'h0, dsp_valid}, 8'h00);
        @(negedge clk);
        check("second transfer count", 8'(xfer_cnt), 8'd2);
        check("second transfer data", {1'b0, xfer_data}, 8'h0D);

        // Push and pop together while empty: push taken, read gives last char
        @(negedge clk);
        kbd_data = 7'h71; kbd_valid = 1'b1; AB = 16'hD010; WE = 1'b0;
        @(negedge clk);
        kbd_valid = 1'b0; AB = 16'h0000;
        check("empty push+pop reads last", dout, 8'hC2);
        rd(16'hD010);
        check("pushed 'q' then popped", dout, 8'hD1);

        // RDY=0: no pop, no register write, sel stays low
        kpush(7'h6B);
        bus(16'hD010, 1'b0, 8'h00, 1'b0);
        check("RDY=0 sel", {7'h0, sel}, 8'h00);
        check("RDY=0 dout holds", dout, 8'hD1);
        bus(16'hD013, 1'b1, 8'h00, 1'b0);
        rd(16'hD013);
        check("RDY=0 write ignored", dout, 8'h27);
        rd(16'hD011);
        check("RDY=0 no pop", dout, 8'hA7);
        rd(16'hD010);
        check("pop 'k' upcased", dout, 8'hCB);

        // Push and pop together while full: only the pop happens
        kpush(7'h41);
        kpush(7'h42);
        kpush(7'h43);
        kpush(7'h44);
        @(negedge clk);
        kbd_data = 7'h45; kbd_valid = 1'b1; AB = 16'hD010; WE = 1'b0;
        #1;
        check("full kbd_ready low", {7'h0, kbd_ready}, 8'h00);
        @(negedge clk);
        kbd_valid = 1'b0; AB = 16'h0000;
        check("full push+pop reads head", dout, 8'hC1);
        rd(16'hD010);
        check("full drain B", dout, 8'hC2);
        rd(16'hD010);
        check("full drain C", dout, 8'hC3);
        rd(16'hD010);
        check("full drain D", dout, 8'hC4);
        rd(16'hD011);
        check("push while full dropped", dout, 8'h27);

        // Mid-stream reset
        kpush(7'h41);
        kpush(7'h42);
        wr(16'hD012, 8'hB0);
        rd(16'hD013);
        check("pre-reset DSPCR", dout, 8'h27);
        check("pre-reset dsp_valid", {7'h0, dsp_valid}, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post-reset dsp_valid", {7'h0, dsp_valid}, 8'h00);
        check("post-reset dsp_data", {1'b0, dsp_data}, 8'h00);
        check("post-reset dout", dout, 8'h00);
        check("post-reset kbd_ready", {7'h0, kbd_ready}, 8'h01);
        rd(16'hD011);
        check("post-reset KBDCR", dout, 8'h00);
        rd(16'hD013);
        check("post-reset DSPCR", dout, 8'h00);
        rd(16'hD010);
        check("post-reset DDRA", dout, 8'h00);
        rd(16'hD012);
        check("post-reset DDRB", dout, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
